// File: rtl/hamming_odd_parity_encoder.sv
// Registered SECDED Hamming(8,4) encoder, odd parity throughout.
// Codeword layout {p8, d3, d2, d1, p4, d0, p2, p1}; one cycle of latency, full throughput.
module hamming_odd_parity_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] data_in,
  output logic [7:0] encoded_data,
  output logic       out_valid
);

  localparam int STAGES = 1;

  typedef struct packed {
    logic       p8;
    logic [2:0] d_hi;
    logic       p4;
    logic       d0;
    logic       p2;
    logic       p1;
  } cw_t;

  cw_t              code_d, code_q;
  logic [STAGES:0]  vld_pipe;

  // Each parity is the inverted XOR of its data group, so the group plus parity has odd weight.
  always_comb begin
    code_d      = '0;
    code_d.p1   = ~(data_in[0] ^ data_in[1] ^ data_in[3]);
    code_d.p2   = ~(data_in[0] ^ data_in[2] ^ data_in[3]);
    code_d.d0   = data_in[0];
    code_d.p4   = ~(data_in[1] ^ data_in[2] ^ data_in[3]);
    code_d.d_hi = data_in[3:1];
    code_d.p8   = ~(^code_d[6:0]);
  end

  assign vld_pipe[0] = in_valid;

  // The codeword register only loads on in_valid, so idle-time junk on data_in never reaches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q           <= '0;
      vld_pipe[STAGES] <= 1'b0;
    end else begin
      vld_pipe[STAGES] <= vld_pipe[STAGES-1];
      if (in_valid) code_q <= code_d;
    end
  end

  assign encoded_data = code_q;
  assign out_valid    = vld_pipe[STAGES];

endmodule

// File: tb/tb_hamming_odd_parity_encoder.sv
// Self-checking bench for hamming_odd_parity_encoder: scoreboard of expected codewords,
// reset behaviour, hold behaviour and single-bit-error syndrome property.
module tb_hamming_odd_parity_encoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] data_in;
  logic [7:0] encoded_data;
  logic       out_valid;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] sb_q[$];
  logic [7:0] cw_seen[16];

  hamming_odd_parity_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .data_in      (data_in),
    .encoded_data (encoded_data),
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Positional Hamming model: parity at position 2^p covers every position with bit p set.
  function automatic logic [7:0] model(input logic [3:0] d);
    logic [7:0] c;
    logic       x;
    c    = '0;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    for (int p = 0; p < 3; p++) begin
      x = 1'b1;
      for (int k = 1; k <= 7; k++)
        if (k[p] && k != (1 << p)) x ^= c[k-1];
      c[(1 << p) - 1] = x;
    end
    c[7] = ~(^c[6:0]);
    return c;
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp_cw;
    rst_n = 1'b0; in_valid = 1'b1; data_in = 4'hF;
    tick(); tick();
    n_total++;
    if (encoded_data !== 8'h00 || out_valid !== 1'b0)
      $display("FAIL reset_hold: got enc=%h vld=%b, want enc=00 vld=0", encoded_data, out_valid);
    else n_pass++;
    rst_n = 1'b1;
    data_in = 4'h5;
    exp_cw = model(4'h5);
    tick();
    n_total++;
    if (encoded_data !== exp_cw || out_valid !== 1'b1)
      $display("FAIL reset_first_word: got enc=%h vld=%b, want enc=%h vld=1", encoded_data, out_valid, exp_cw);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (encoded_data !== 8'h00 || out_valid !== 1'b0)
      $display("FAIL reset_async: got enc=%h vld=%b, want enc=00 vld=0", encoded_data, out_valid);
    else n_pass++;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_exhaustive();
    logic [7:0] exp_cw;
    logic [7:0] ref_cw[4];
    logic [3:0] ref_d[4];
    ref_d  = '{4'h0, 4'h1, 4'hA, 4'hF};
    ref_cw = '{8'h0B, 8'h8C, 8'hD9, 8'hF4};
    sb_q.delete();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      data_in  = i[3:0];
      sb_q.push_back(model(i[3:0]));
      tick();
      n_total++;
      if (out_valid !== 1'b1 || sb_q.size() == 0) begin
        $display("FAIL enc_valid[%0d]: got vld=%b queue=%0d, want vld=1", i, out_valid, sb_q.size());
      end else begin
        exp_cw = sb_q.pop_front();
        if (encoded_data !== exp_cw)
          $display("FAIL enc_word[%0d]: got %h, want %h", i, encoded_data, exp_cw);
        else n_pass++;
      end
      cw_seen[i] = encoded_data;
      n_total++;
      if ((^encoded_data) !== 1'b1)
        $display("FAIL enc_odd_weight[%0d]: got xor=%b, want 1", i, ^encoded_data);
      else n_pass++;
      for (int r = 0; r < 4; r++)
        if (ref_d[r] == i[3:0]) begin
          n_total++;
          if (encoded_data !== ref_cw[r])
            $display("FAIL enc_const[%h]: got %h, want %h", ref_d[r], encoded_data, ref_cw[r]);
          else n_pass++;
        end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    in_valid = 1'b1; data_in = 4'h1;
    tick();
    n_total++;
    if (encoded_data !== 8'h8C || out_valid !== 1'b1)
      $display("FAIL hold_load: got enc=%h vld=%b, want enc=8c vld=1", encoded_data, out_valid);
    else n_pass++;
    in_valid = 1'b0; data_in = 4'hF;
    tick();
    n_total++;
    if (encoded_data !== 8'h8C || out_valid !== 1'b0)
      $display("FAIL hold_idle: got enc=%h vld=%b, want enc=8c vld=0", encoded_data, out_valid);
    else n_pass++;
    data_in = 4'bxxxx;
    tick(); tick();
    n_total++;
    if (encoded_data !== 8'h8C || out_valid !== 1'b0)
      $display("FAIL hold_x_input: got enc=%h vld=%b, want enc=8c vld=0", encoded_data, out_valid);
    else n_pass++;
    data_in = 4'h0;
  endtask

  task automatic test_single_bit_error();
    logic [7:0] c;
    logic [2:0] syn, exp_syn;
    for (int w = 0; w < 16; w++)
      for (int j = 0; j < 8; j++) begin
        c = cw_seen[w];
        c[j] = ~c[j];
        syn[0] = ~(c[0] ^ c[2] ^ c[4] ^ c[6]);
        syn[1] = ~(c[1] ^ c[2] ^ c[5] ^ c[6]);
        syn[2] = ~(c[3] ^ c[4] ^ c[5] ^ c[6]);
        exp_syn = (j < 7) ? 3'(j + 1) : 3'd0;
        n_total++;
        if (syn !== exp_syn)
          $display("FAIL sbe_syndrome[w%0d b%0d]: got %0d, want %0d", w, j, syn, exp_syn);
        else n_pass++;
        n_total++;
        if ((^c) !== 1'b0)
          $display("FAIL sbe_overall[w%0d b%0d]: got xor=%b, want 0", w, j, ^c);
        else n_pass++;
      end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] exp_cw;
    sb_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (i == 7) begin
        rst_n = 1'b0; in_valid = 1'b0;
        sb_q.delete();
        #1;
        n_total++;
        if (encoded_data !== 8'h00 || out_valid !== 1'b0)
          $display("FAIL mid_reset_clear: got enc=%h vld=%b, want enc=00 vld=0", encoded_data, out_valid);
        else n_pass++;
        tick();
        rst_n = 1'b1;
      end
      in_valid = 1'b1;
      data_in  = i[3:0];
      sb_q.push_back(model(i[3:0]));
      tick();
      n_total++;
      if (out_valid !== 1'b1 || sb_q.size() == 0) begin
        $display("FAIL mid_valid[%0d]: got vld=%b queue=%0d, want vld=1", i, out_valid, sb_q.size());
      end else begin
        exp_cw = sb_q.pop_front();
        if (encoded_data !== exp_cw)
          $display("FAIL mid_word[%0d]: got %h, want %h", i, encoded_data, exp_cw);
        else n_pass++;
      end
    end
    in_valid = 1'b0;
    tick();
    n_total++;
    if (out_valid !== 1'b0 || sb_q.size() != 0)
      $display("FAIL mid_drain: got vld=%b queue=%0d, want vld=0 queue=0", out_valid, sb_q.size());
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; data_in = 4'h0;
    test_reset();
    test_exhaustive();
    test_hold();
    test_single_bit_error();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
